// File: rtl/tone_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tone_sched_if                                                   |
// | Purpose  : Bundles the requester handshake and the tone generator drive    |
// |            signals of tone_sched.                                          |
// |            master = requester/control side, slave = tone_sched.            |
// | Signals  : req, req_note, req_dur        requester -> scheduler            |
// |            grant, done, aborted          scheduler -> requester            |
// |            tone_en, tone_note            scheduler -> note generator       |
// |            busy, active_id               scheduler status                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface tone_sched_if #(
  parameter int NUM_REQ = 3,
  parameter int NOTE_W  = 3,
  parameter int DUR_W   = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*NOTE_W-1:0] req_note;
  logic [NUM_REQ*DUR_W-1:0]  req_dur;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        done;
  logic                      aborted;
  logic                      tone_en;
  logic [NOTE_W-1:0]         tone_note;
  logic                      busy;
  logic [ID_W-1:0]           active_id;

  modport master (
    output req, req_note, req_dur,
    input  grant, done, aborted, tone_en, tone_note, busy, active_id
  );

  modport slave (
    input  req, req_note, req_dur,
    output grant, done, aborted, tone_en, tone_note, busy, active_id
  );
endinterface
`default_nettype wire

// File: rtl/tone_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tone_sched                                                      |
// | Purpose  : Shares one square-wave note generator between NUM_REQ          |
// |            requesters. Fixed priority (index 0 highest), plays the        |
// |            winner's note for dur*TEMPO_DIV clocks, then a GAP_CLK silent   |
// |            gap, and reports completion per requester.                      |
// | Ports    : clk    clock                                                    |
// |            rst_l  asynchronous active-low reset                            |
// |            bus    tone_sched_if.slave (requests in; grant/done/aborted,    |
// |                   tone_en/tone_note, busy/active_id out; all registered)  |
// | Options  : PREEMPT_EN  when defined, a higher-priority request aborts the |
// |            note being played; otherwise aborted is tied to 0.              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tone_sched #(
  parameter int CLK_REF   = 50_000_000,
  parameter int NUM_REQ   = 3,
  parameter int NOTE_W    = 3,
  parameter int DUR_W     = 4,
  parameter int TEMPO_DIV = CLK_REF / 8,
  parameter int GAP_CLK   = CLK_REF / 100
) (
  input  wire logic   clk,
  input  wire logic   rst_l,
  tone_sched_if.slave bus
);
  localparam int ID_W    = (NUM_REQ > 1)   ? $clog2(NUM_REQ)   : 1;
  localparam int PRESC_W = (TEMPO_DIV > 1) ? $clog2(TEMPO_DIV) : 1;
  localparam int GAP_W   = (GAP_CLK > 1)   ? $clog2(GAP_CLK)   : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TEMPO_DIV - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CLK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [PRESC_W-1:0]   presc, presc_n;
  logic [DUR_W-1:0]     beat, beat_n, beat_inc;
  logic [DUR_W-1:0]     dur_q, dur_n;
  logic [GAP_W-1:0]     gap, gap_n;
  logic                 pend_done, pend_n;
  logic [NUM_REQ-1:0]   grant_q, grant_n, done_q, done_n;
  logic                 tone_en_q, tone_en_n;
  logic [NOTE_W-1:0]    note_q, note_n;
  logic                 busy_q, busy_n;
  logic [ID_W-1:0]      id_q, id_n;
  logic                 load;

  // Fixed-priority winner: scan downward so the lowest asserted index wins.
  logic                 have_req;
  logic [ID_W-1:0]      win;
  logic [NOTE_W-1:0]    win_note;
  logic [DUR_W-1:0]     win_dur;

  always_comb begin
    have_req = 1'b0;
    win      = '0;
    win_note = '0;
    win_dur  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        have_req = 1'b1;
        win      = ID_W'(i);
        win_note = bus.req_note[i*NOTE_W +: NOTE_W];
        win_dur  = bus.req_dur[i*DUR_W +: DUR_W];
      end
    end
  end

  assign beat_inc = beat + DUR_W'(1);

`ifdef PREEMPT_EN
  logic aborted_q, aborted_n;
`endif

  always_comb begin
    state_n   = state;
    presc_n   = presc;
    beat_n    = beat;
    dur_n     = dur_q;
    gap_n     = gap;
    pend_n    = 1'b0;
    grant_n   = '0;
    done_n    = '0;
    tone_en_n = tone_en_q;
    note_n    = note_q;
    busy_n    = busy_q;
    id_n      = id_q;
    load      = 1'b0;
`ifdef PREEMPT_EN
    aborted_n = 1'b0;
`endif
    case (state)
      IDLE: begin
        busy_n    = 1'b0;
        tone_en_n = 1'b0;
        note_n    = '0;
        // Zero-duration grant reports completion one cycle after the grant.
        if (pend_done) done_n = NUM_REQ'(1) << id_q;
        if (have_req) load = 1'b1;
      end
      PLAY: begin
        if (presc == PRESC_LAST && beat_inc == dur_q) begin
          done_n    = NUM_REQ'(1) << id_q;
          tone_en_n = 1'b0;
          note_n    = '0;
          gap_n     = '0;
          state_n   = GAP;
        end
`ifdef PREEMPT_EN
        else if (have_req && win < id_q) begin
          done_n    = NUM_REQ'(1) << id_q;
          aborted_n = 1'b1;
          load      = 1'b1;
        end
`endif
        else if (presc == PRESC_LAST) begin
          presc_n = '0;
          beat_n  = beat_inc;
        end else begin
          presc_n = presc + PRESC_W'(1);
        end
      end
      GAP: begin
        if (gap == GAP_LAST) begin
          if (have_req) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end else begin
          gap_n = gap + GAP_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Arbitration edge: latch the winner's note/duration and restart counters.
    if (load) begin
      grant_n = NUM_REQ'(1) << win;
      id_n    = win;
      busy_n  = 1'b1;
      dur_n   = win_dur;
      presc_n = '0;
      beat_n  = '0;
      gap_n   = '0;
      if (win_dur != '0) begin
        state_n   = PLAY;
        tone_en_n = (win_note != '0);
        note_n    = win_note;
      end else begin
        state_n   = IDLE;
        pend_n    = 1'b1;
        tone_en_n = 1'b0;
        note_n    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state     <= IDLE;
      presc     <= '0;
      beat      <= '0;
      dur_q     <= '0;
      gap       <= '0;
      pend_done <= 1'b0;
      grant_q   <= '0;
      done_q    <= '0;
      tone_en_q <= 1'b0;
      note_q    <= '0;
      busy_q    <= 1'b0;
      id_q      <= '0;
    end else begin
      state     <= state_n;
      presc     <= presc_n;
      beat      <= beat_n;
      dur_q     <= dur_n;
      gap       <= gap_n;
      pend_done <= pend_n;
      grant_q   <= grant_n;
      done_q    <= done_n;
      tone_en_q <= tone_en_n;
      note_q    <= note_n;
      busy_q    <= busy_n;
      id_q      <= id_n;
    end
  end

`ifdef PREEMPT_EN
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) aborted_q <= 1'b0;
    else        aborted_q <= aborted_n;
  end
  assign bus.aborted = aborted_q;
`else
  assign bus.aborted = 1'b0;
`endif

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.tone_en   = tone_en_q;
  assign bus.tone_note = note_q;
  assign bus.busy      = busy_q;
  assign bus.active_id = id_q;
endmodule
`default_nettype wire

// File: tb/tb_tone_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_tone_sched                                                   |
// | Purpose  : Directed self-checking bench for tone_sched with               |
// |            TEMPO_DIV=10, GAP_CLK=4, NUM_REQ=3. The pre-emption scenario    |
// |            follows PREEMPT_EN: aborts when defined, waits otherwise.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_tone_sched;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  tone_sched_if #(.NUM_REQ(3), .NOTE_W(3), .DUR_W(4)) bus ();

  tone_sched #(
    .CLK_REF(1000), .NUM_REQ(3), .NOTE_W(3), .DUR_W(4),
    .TEMPO_DIV(10), .GAP_CLK(4)
  ) dut (
    .clk(clk),
    .rst_l(rst_l),
    .bus(bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] n, input logic [3:0] d, input logic r);
    bus.req_note[i*3 +: 3] = n;
    bus.req_dur[i*4 +: 4]  = d;
    bus.req[i]             = r;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100 && bus.busy; k++) step();
    step();
  endtask

  task automatic test_reset();
    bus.req = '0; bus.req_note = '0; bus.req_dur = '0;
    rst_l = 1'b0;
    step(); step();
    checks++; if (bus.grant !== 3'b000 || bus.done !== 3'b000) $display("FAIL reset_pulses: grant=%b done=%b expected 000/000", bus.grant, bus.done); else passes++;
    checks++; if (bus.busy !== 1'b0 || bus.tone_en !== 1'b0 || bus.aborted !== 1'b0) $display("FAIL reset_flags: busy=%b tone_en=%b aborted=%b expected 0", bus.busy, bus.tone_en, bus.aborted); else passes++;
    checks++; if (bus.tone_note !== 3'd0 || bus.active_id !== 2'd0) $display("FAIL reset_note_id: note=%0d id=%0d expected 0/0", bus.tone_note, bus.active_id); else passes++;
    rst_l = 1'b1;
    step();
  endtask

  task automatic test_single_note();
    int cnt, gcnt, dcnt;
    logic note_ok;
    set_req(0, 3'd3, 4'd2, 1'b1);
    step();
    checks++; if (bus.grant !== 3'b001 || bus.busy !== 1'b1 || bus.active_id !== 2'd0) $display("FAIL t1_grant: grant=%b busy=%b id=%0d expected 001/1/0", bus.grant, bus.busy, bus.active_id); else passes++;
    set_req(0, 3'd0, 4'd0, 1'b0);
    cnt = 0; dcnt = 0; note_ok = 1'b1;
    for (int k = 0; k < 40 && bus.tone_en === 1'b1; k++) begin
      cnt++;
      if (bus.tone_note !== 3'd3) note_ok = 1'b0;
      if (bus.done !== 3'b000) dcnt++;
      step();
    end
    checks++; if (cnt != 20) $display("FAIL t1_play_len: got %0d cycles expected 20", cnt); else passes++;
    checks++; if (!note_ok) $display("FAIL t1_note: tone_note not held at 3"); else passes++;
    checks++; if (bus.done !== 3'b001 || dcnt != 0) $display("FAIL t1_done: done=%b early=%0d expected 001/0", bus.done, dcnt); else passes++;
    gcnt = 0;
    for (int k = 0; k < 20 && bus.busy === 1'b1; k++) begin
      gcnt++;
      if (bus.tone_en !== 1'b0) gcnt += 100;
      if (k > 0 && bus.done !== 3'b000) gcnt += 100;
      step();
    end
    checks++; if (gcnt != 4) $display("FAIL t1_gap: got %0d expected 4 quiet gap cycles", gcnt); else passes++;
    step();
  endtask

  task automatic test_priority();
    int cnt;
    set_req(0, 3'd3, 4'd2, 1'b1);
    set_req(2, 3'd6, 4'd1, 1'b1);
    step();
    checks++; if (bus.grant !== 3'b001 || bus.tone_note !== 3'd3) $display("FAIL t2_first: grant=%b note=%0d expected 001/3", bus.grant, bus.tone_note); else passes++;
    set_req(0, 3'd0, 4'd0, 1'b0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      cnt++;
      if (bus.grant !== 3'b000) break;
    end
    checks++; if (cnt != 24 || bus.grant !== 3'b100) $display("FAIL t2_second: grant=%b after %0d cycles expected 100 after 24", bus.grant, cnt); else passes++;
    checks++; if (bus.tone_note !== 3'd6 || bus.tone_en !== 1'b1 || bus.active_id !== 2'd2) $display("FAIL t2_note: note=%0d en=%b id=%0d expected 6/1/2", bus.tone_note, bus.tone_en, bus.active_id); else passes++;
    set_req(2, 3'd0, 4'd0, 1'b0);
    wait_idle();
  endtask

  task automatic test_zero_dur();
    set_req(1, 3'd5, 4'd0, 1'b1);
    step();
    checks++; if (bus.grant !== 3'b010 || bus.busy !== 1'b1 || bus.tone_en !== 1'b0) $display("FAIL t3_grant: grant=%b busy=%b en=%b expected 010/1/0", bus.grant, bus.busy, bus.tone_en); else passes++;
    set_req(1, 3'd0, 4'd0, 1'b0);
    step();
    checks++; if (bus.done !== 3'b010 || bus.busy !== 1'b0 || bus.tone_en !== 1'b0 || bus.grant !== 3'b000) $display("FAIL t3_done: done=%b busy=%b en=%b grant=%b expected 010/0/0/000", bus.done, bus.busy, bus.tone_en, bus.grant); else passes++;
    step();
    checks++; if (bus.done !== 3'b000 || bus.busy !== 1'b0) $display("FAIL t3_after: done=%b busy=%b expected 000/0", bus.done, bus.busy); else passes++;
  endtask

  task automatic test_rest_note();
    int idx, done_idx, bcnt;
    logic en_seen;
    set_req(2, 3'd0, 4'd3, 1'b1);
    step();
    checks++; if (bus.grant !== 3'b100 || bus.tone_note !== 3'd0) $display("FAIL t4_grant: grant=%b note=%0d expected 100/0", bus.grant, bus.tone_note); else passes++;
    set_req(2, 3'd0, 4'd0, 1'b0);
    idx = 0; done_idx = -1; bcnt = 0; en_seen = 1'b0;
    for (int k = 0; k < 60 && bus.busy === 1'b1; k++) begin
      bcnt++;
      if (bus.tone_en !== 1'b0) en_seen = 1'b1;
      if (bus.done === 3'b100) done_idx = idx;
      idx++;
      step();
    end
    checks++; if (en_seen) $display("FAIL t4_tone_en: got tone_en high expected 0 throughout"); else passes++;
    checks++; if (bcnt != 34) $display("FAIL t4_busy: got %0d busy cycles expected 34", bcnt); else passes++;
    checks++; if (done_idx != 30) $display("FAIL t4_done: got done at %0d expected 30", done_idx); else passes++;
    step();
  endtask

  task automatic test_reset_mid_play();
    int bad;
    set_req(0, 3'd4, 4'd2, 1'b1);
    step();
    set_req(0, 3'd0, 4'd0, 1'b0);
    for (int k = 0; k < 6; k++) step();
    checks++; if (bus.tone_en !== 1'b1 || bus.tone_note !== 3'd4) $display("FAIL t5_playing: en=%b note=%0d expected 1/4", bus.tone_en, bus.tone_note); else passes++;
    rst_l = 1'b0;
    #1;
    checks++; if (bus.tone_en !== 1'b0 || bus.busy !== 1'b0 || bus.tone_note !== 3'd0 || bus.grant !== 3'b000 || bus.done !== 3'b000) $display("FAIL t5_async: en=%b busy=%b note=%0d grant=%b done=%b expected all 0", bus.tone_en, bus.busy, bus.tone_note, bus.grant, bus.done); else passes++;
    step(); step();
    rst_l = 1'b1;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (bus.busy !== 1'b0 || bus.done !== 3'b000 || bus.grant !== 3'b000 || bus.tone_en !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL t5_idle: got %0d active cycles expected 0", bad); else passes++;
  endtask

  task automatic test_preempt();
    int cnt;
    set_req(2, 3'd2, 4'd5, 1'b1);
    step();
    checks++; if (bus.grant !== 3'b100) $display("FAIL t6_grant2: grant=%b expected 100", bus.grant); else passes++;
    set_req(2, 3'd0, 4'd0, 1'b0);
    for (int k = 0; k < 15; k++) step();
    set_req(0, 3'd5, 4'd1, 1'b1);
    step();
`ifdef PREEMPT_EN
    checks++; if (bus.done !== 3'b100 || bus.aborted !== 1'b1 || bus.grant !== 3'b001) $display("FAIL t6_preempt: done=%b aborted=%b grant=%b expected 100/1/001", bus.done, bus.aborted, bus.grant); else passes++;
    set_req(0, 3'd0, 4'd0, 1'b0);
    cnt = 0;
    for (int k = 0; k < 30 && bus.tone_en === 1'b1 && bus.tone_note === 3'd5; k++) begin
      cnt++;
      step();
    end
    checks++; if (cnt != 10) $display("FAIL t6_len: got %0d cycles of note 5 expected 10", cnt); else passes++;
    checks++; if (bus.done !== 3'b001 || bus.aborted !== 1'b0) $display("FAIL t6_done0: done=%b aborted=%b expected 001/0", bus.done, bus.aborted); else passes++;
`else
    checks++; if (bus.done !== 3'b000 || bus.aborted !== 1'b0 || bus.grant !== 3'b000 || bus.tone_note !== 3'd2) $display("FAIL t6_nopreempt: done=%b aborted=%b grant=%b note=%0d expected 000/0/000/2", bus.done, bus.aborted, bus.grant, bus.tone_note); else passes++;
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      cnt++;
      if (bus.grant !== 3'b000) break;
    end
    checks++; if (cnt != 38 || bus.grant !== 3'b001) $display("FAIL t6_wait: grant=%b after %0d cycles expected 001 after 38", bus.grant, cnt); else passes++;
    set_req(0, 3'd0, 4'd0, 1'b0);
    checks++; if (bus.aborted !== 1'b0 || bus.tone_note !== 3'd5) $display("FAIL t6_note: aborted=%b note=%0d expected 0/5", bus.aborted, bus.tone_note); else passes++;
`endif
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_priority();
    test_zero_dur();
    test_rest_note();
    test_reset_mid_play();
    test_preempt();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/tone_sched.md
Name: tone_sched

Overview:
Scheduler that shares one tone generator (square-wave note player) between several requesters, e.g. key-click beep, alarm and melody sequencer. It arbitrates by fixed priority and latches the winner's note index and duration. It then drives the generator's enable/note inputs for an exact number of tempo beats, inserts a silent gap between notes, and reports completion per requester. Sits between the control logic and the buzzer note datapath.

Parameters:
CLK_REF, 50_000_000, clk frequency in Hz (documentation, default derivations)
NUM_REQ, 3, number of requesters; index 0 = highest priority
NOTE_W, 3, note index width; 0 = rest, 1..7 = DO..SI
DUR_W, 4, duration width in beats
TEMPO_DIV, CLK_REF/8, clk cycles per beat (>=1)
GAP_CLK, CLK_REF/100, silent clk cycles after each played note (>=1)

Ports:
clk  in  1  clock
rst_l  in  1  asynchronous, active-low reset
req  in  NUM_REQ  level request per requester, held until grant
req_note  in  NUM_REQ*NOTE_W  packed note index, requester i at [i*NOTE_W +: NOTE_W]
req_dur  in  NUM_REQ*DUR_W  packed duration in beats, same packing
grant  out  NUM_REQ  one-hot, 1-cycle pulse; request accepted
done  out  NUM_REQ  one-hot, 1-cycle pulse; granted request finished
aborted  out  1  qualifies done: request was pre-empted (PREEMPT_EN only)
tone_en  out  1  generator enable
tone_note  out  NOTE_W  note index to generator
busy  out  1  high in PLAY or GAP
active_id  out  $clog2(NUM_REQ)  index of current owner; valid while busy

Behaviour:
- Reset (async, rst_l=0): state IDLE; grant, done, aborted, tone_en, busy = 0; tone_note = 0; active_id = 0; counters cleared. Reset mid-PLAY/GAP aborts silently: no done pulse. Outputs resume only after rst_l deasserts and a new arbitration occurs.
- All outputs registered. States: IDLE, PLAY, GAP.
- Arbitration edge: any edge in IDLE, or the edge ending the last GAP cycle. Winner = lowest i with req[i]=1; no req -> IDLE.
- On the arbitration edge: grant[winner]=1 for 1 cycle; latch note and dur; active_id=winner; busy=1.
  - dur>0: enter PLAY; tone_en=(note!=0); tone_note=note; beat prescaler and beat counter start at 0.
  - dur=0: enter IDLE; done[winner] pulses the following cycle; no PLAY, no GAP, tone_en stays 0.
- PLAY: tone_en/tone_note stay constant for exactly dur*TEMPO_DIV cycles. Prescaler wraps at TEMPO_DIV-1 and each wrap increments the beat counter. On the edge where the beat counter reaches dur: done[owner]=1 for 1 cycle, tone_en=0, tone_note=0, enter GAP.
- Rest note (0): timing identical to a played note; tone_en held 0 throughout.
- GAP: exactly GAP_CLK cycles with tone_en=0 and busy=1. Its final edge is an arbitration edge; with no pending req -> IDLE, busy=0.
- Requester rules:
  - Note and dur are sampled only on the grant edge.
  - Dropping req before grant withdraws the request.
  - req still high after grant is treated as a new request at the next arbitration edge.
  - Changing note/dur while holding req is allowed; the value at grant is used.
- Simultaneous requests: resolved purely by priority; the loser keeps req high and waits. Higher priority may starve lower priority; this is intended.
- Width rules: beat counter DUR_W bits; prescaler $clog2(TEMPO_DIV) bits; gap counter $clog2(GAP_CLK) bits. No overflow is possible for legal parameters.

Optional Feature:
PREEMPT_EN
- Defined: in PLAY, a req[j] with j < active_id triggers pre-emption. On the next edge, done[old]=1 and aborted=1 for 1 cycle, and grant[j] fires in the same cycle. The new note starts immediately with no GAP and its counters restart. Requests with j >= active_id wait as normal. GAP is never pre-empted.
- Undefined: no pre-emption; aborted tied to 0.

Test Plan:
Bench parameters: TEMPO_DIV=10, GAP_CLK=4, NUM_REQ=3.
1. req[0] note=3 dur=2 -> grant[0] 1 cycle; tone_en=1, tone_note=3 for exactly 20 cycles; then done[0] pulse; tone_en=0 and busy=1 for 4 cycles; then busy=0.
2. req[0] and req[2] asserted on the same cycle -> grant[0] first; grant[2] on the edge ending the gap, 24 cycles after grant[0]; tone_note changes 3 -> req_note[2].
3. req[1] dur=0 -> grant[1], then done[1] next cycle; tone_en never high; busy high 1 cycle; no gap.
4. req[2] note=0 dur=3 -> tone_en=0 throughout; busy=1 for 30+4 cycles; done[2] at cycle 30.
5. rst_l pulled low at cycle 7 of PLAY -> all outputs 0 immediately; no done; after release with req low, remains IDLE.
6. PREEMPT_EN: req[2] dur=5 playing; req[0] note=5 dur=1 asserted at cycle 15 -> next cycle done[2]+aborted+grant[0]; tone_note=5 for 10 cycles; done[0] with aborted=0.
